// File: rtl/mlp_host_sequencer.sv
// rtl/mlp_host_sequencer.sv - byte-stream command sequencer for the MLP load/control port
// Decodes host opcodes into registered single-cycle datapath pulses and one-byte status responses.
module mlp_host_sequencer #(
  parameter int          MAX_ACT_WORDS    = 16,
  parameter int          TIMEOUT_CYCLES   = 1024,
  parameter logic [3:0]  LOAD_WEIGHT_CODE = 4'd1,
  parameter logic [7:0]  DONE_RESP        = 8'hA5,
  parameter logic [7:0]  ERR_RESP         = 8'hEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wf_push_col0,
  output logic        wf_push_col1,
  output logic [7:0]  wf_data_in,
  output logic        wf_reset,
  output logic        init_act_valid,
  output logic [15:0] init_act_data,
  output logic        start_mlp,
  output logic        weights_ready,
  input  logic [3:0]  mlp_state,
  input  logic        layer_complete,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  input  logic        resp_ready,
  output logic        busy,
  output logic        err
);

  localparam int         TCW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0] MAX_N = 8'(MAX_ACT_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_W_DATA, S_A_CNT, S_A_LO, S_A_HI, S_WR_HOLD, S_WAIT_DONE, S_RESP
  } state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_wcnt;
  logic [7:0]       r_acnt;
  logic [7:0]       r_lo;
  logic [TCW-1:0]   r_tcnt;
  logic             r_push0, r_push1, r_wf_reset, r_init_valid, r_start, r_wr, r_err;
  logic [7:0]       r_wf_data;
  logic [15:0]      r_init_data;
  logic             r_resp_valid;
  logic [7:0]       r_resp_data;

  logic             w_in_ready, w_acc, w_tmo, w_wr_ack;
  logic             w_push0, w_push1, w_wf_reset, w_init_valid, w_start;
  logic [7:0]       w_wf_data;
  logic [15:0]      w_init_data;
  logic             w_err_evt, w_done_evt;

  assign w_in_ready = ((r_state == S_IDLE) && !r_resp_valid) || (r_state == S_W_DATA) ||
                      (r_state == S_A_CNT) || (r_state == S_A_LO) || (r_state == S_A_HI);
  assign w_acc    = in_valid & w_in_ready;
  assign w_tmo    = (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));
  assign w_wr_ack = (mlp_state == LOAD_WEIGHT_CODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_acc) begin
        case (in_data)
          8'h01:        w_next = S_W_DATA;
          8'h02:        w_next = S_A_CNT;
          8'h03, 8'h06: w_next = S_IDLE;
          8'h04:        w_next = S_WR_HOLD;
          8'h05:        w_next = S_WAIT_DONE;
          default:      w_next = S_RESP;
        endcase
      end
      S_W_DATA: if (w_acc && r_wcnt == 2'd3) w_next = S_IDLE;
      S_A_CNT: if (w_acc) begin
        if (in_data == 8'd0)       w_next = S_IDLE;
        else if (in_data > MAX_N)  w_next = S_RESP;
        else                       w_next = S_A_LO;
      end
      S_A_LO: if (w_acc) w_next = S_A_HI;
      S_A_HI: if (w_acc) w_next = (r_acnt == 8'd1) ? S_IDLE : S_A_LO;
      S_WR_HOLD: begin
        if (w_wr_ack)   w_next = S_IDLE;
        else if (w_tmo) w_next = S_RESP;
      end
      S_WAIT_DONE: if (layer_complete || w_tmo) w_next = S_RESP;
      S_RESP: if (r_resp_valid && resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Next-cycle values of the registered datapath strobes, one per accepting handshake.
  always_comb begin
    w_push0      = 1'b0;
    w_push1      = 1'b0;
    w_wf_data    = 8'h00;
    w_wf_reset   = 1'b0;
    w_init_valid = 1'b0;
    w_init_data  = 16'h0000;
    w_start      = 1'b0;
    w_err_evt    = 1'b0;
    w_done_evt   = 1'b0;
    case (r_state)
      S_IDLE: if (w_acc) begin
        case (in_data)
          8'h03:                      w_start    = 1'b1;
          8'h06:                      w_wf_reset = 1'b1;
          8'h01, 8'h02, 8'h04, 8'h05: w_err_evt  = 1'b0;
          default:                    w_err_evt  = 1'b1;
        endcase
      end
      S_W_DATA: if (w_acc) begin
        w_push0   = ~r_wcnt[1];
        w_push1   = r_wcnt[1];
        w_wf_data = in_data;
      end
      S_A_CNT: if (w_acc && in_data > MAX_N) w_err_evt = 1'b1;
      S_A_HI: if (w_acc) begin
        w_init_valid = 1'b1;
        w_init_data  = {in_data, r_lo};
      end
      S_WR_HOLD: if (!w_wr_ack && w_tmo) w_err_evt = 1'b1;
      S_WAIT_DONE: begin
        if (layer_complete) w_done_evt = 1'b1;
        else if (w_tmo)     w_err_evt  = 1'b1;
      end
      default: w_err_evt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_push0      <= 1'b0;
      r_push1      <= 1'b0;
      r_wf_data    <= 8'h00;
      r_wf_reset   <= 1'b0;
      r_init_valid <= 1'b0;
      r_init_data  <= 16'h0000;
      r_start      <= 1'b0;
      r_wr         <= 1'b0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 8'h00;
      r_wcnt       <= 2'd0;
      r_acnt       <= 8'd0;
      r_lo         <= 8'h00;
      r_tcnt       <= '0;
    end else begin
      r_push0      <= w_push0;
      r_push1      <= w_push1;
      r_wf_data    <= w_wf_data;
      r_wf_reset   <= w_wf_reset;
      r_init_valid <= w_init_valid;
      r_init_data  <= w_init_data;
      r_start      <= w_start;
      r_wr         <= (w_next == S_WR_HOLD);
      r_err        <= r_err | w_err_evt;
      if (w_err_evt || w_done_evt) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_done_evt ? DONE_RESP : ERR_RESP;
      end else if (r_resp_valid && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
      if (r_state == S_IDLE)            r_wcnt <= 2'd0;
      else if (r_state == S_W_DATA && w_acc) r_wcnt <= r_wcnt + 2'd1;
      if (r_state == S_A_CNT && w_acc)       r_acnt <= in_data;
      else if (r_state == S_A_HI && w_acc)   r_acnt <= r_acnt - 8'd1;
      if (r_state == S_A_LO && w_acc)        r_lo <= in_data;
      // Entry to the wait states is always from IDLE, so clearing outside them clears on entry.
      if (r_state == S_WR_HOLD || r_state == S_WAIT_DONE) r_tcnt <= r_tcnt + 1'b1;
      else                                                r_tcnt <= '0;
    end
  end

  assign in_ready       = w_in_ready;
  assign wf_push_col0   = r_push0;
  assign wf_push_col1   = r_push1;
  assign wf_data_in     = r_wf_data;
  assign wf_reset       = r_wf_reset;
  assign init_act_valid = r_init_valid;
  assign init_act_data  = r_init_data;
  assign start_mlp      = r_start;
  assign weights_ready  = r_wr;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign busy           = (r_state != S_IDLE) || r_resp_valid;
  assign err            = r_err;

endmodule

// File: doc/mlp_host_sequencer.md
Name: mlp_host_sequencer

Overview:
Host-side command sequencer that drives the control/load side of the MLP datapath top: weight-FIFO pushes, initial activation writes, start, and per-layer weights_ready. It consumes a byte stream (valid/ready, e.g. from a UART bridge) and decodes opcodes into cycle-accurate pulses. It watches the MLP FSM state and layer_complete, and returns one-byte status responses on a valid/ready output.

Parameters:
MAX_ACT_WORDS, 16, maximum activation words per LOAD_ACT (matches unified buffer depth)
TIMEOUT_CYCLES, 1024, cycle limit for WR_HOLD and WAIT_DONE before error
LOAD_WEIGHT_CODE, 4'd1, MLP state encoding that acknowledges weights_ready
DONE_RESP, 8'hA5, response byte on completion
ERR_RESP, 8'hEE, response byte on any error

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
in_valid  in  1  command byte valid
in_data  in  8  command byte
in_ready  out  1  byte accepted when in_valid&in_ready
wf_push_col0  out  1  push wf_data_in into weight FIFO column 0
wf_push_col1  out  1  push wf_data_in into weight FIFO column 1
wf_data_in  out  8  weight byte
wf_reset  out  1  weight FIFO reset pulse
init_act_valid  out  1  initial activation write strobe
init_act_data  out  16  {row1_byte, row0_byte}
start_mlp  out  1  start pulse
weights_ready  out  1  next-layer weights available (held)
mlp_state  in  4  MLP FSM state
layer_complete  in  1  MLP done flag (sticky in MLP)
resp_valid  out  1  response byte valid
resp_data  out  8  response byte
resp_ready  in  1  response consumer ready
busy  out  1  FSM not in IDLE
err  out  1  sticky error flag

Behaviour:
- Reset: async, active-high; clock clk. All outputs 0; FSM IDLE; err=0; response register empty. Reset mid-command abandons it with no further pulses.
- One byte accepted per cycle maximum. Every datapath output (push, init_act, start, wf_reset) is registered: a single-cycle pulse in the cycle after the accepting handshake, with data captured from that byte.
- in_ready=1 only in IDLE, W_DATA, A_CNT, A_LO, A_HI, and never while a response is pending in IDLE.
- States: IDLE, W_DATA, A_CNT, A_LO, A_HI, WR_HOLD, WAIT_DONE, RESP.
- Opcodes decoded in IDLE:
  - 0x01 LOAD_W -> W_DATA. Accepts 4 bytes: bytes 0,1 -> wf_push_col0; bytes 2,3 -> wf_push_col1. 2-bit counter; IDLE after byte 3.
  - 0x02 LOAD_ACT -> A_CNT. Count byte n:
    - n=0: IDLE, no strobes.
    - n>MAX_ACT_WORDS: err=1, RESP(ERR_RESP), payload not consumed.
    - Otherwise alternate A_LO/A_HI n times. After each hi byte, init_act_valid=1 for one cycle with data {hi,lo}. IDLE after word n.
  - 0x03 START -> start_mlp one cycle.
  - 0x04 WEIGHTS_READY -> WR_HOLD. weights_ready held 1 until mlp_state==LOAD_WEIGHT_CODE is sampled, then 0 next cycle and IDLE.
  - 0x05 WAIT_DONE -> WAIT_DONE. When layer_complete=1 is sampled, go to RESP(DONE_RESP). If already 1 on entry, the response is loaded the next cycle.
  - 0x06 WF_RESET -> wf_reset one cycle.
  - Any other opcode: err=1, RESP(ERR_RESP).
- Timeout: the counter clears on entry to WR_HOLD/WAIT_DONE and increments every cycle there. When it reaches TIMEOUT_CYCLES-1 without the exit condition: drop weights_ready, err=1, RESP(ERR_RESP).
- RESP: loads resp_data and sets resp_valid. It holds until resp_valid&resp_ready, then IDLE. resp_data is stable while valid. Exactly one response per WAIT_DONE or error event.
- wf_push_col0 and wf_push_col1 are never both asserted. init_act_valid and pushes never overlap, because each is driven by a different state.
- busy=(state!=IDLE) || resp_valid.
- err is sticky until reset.

Test Plan:
- LOAD_W bytes 01,11,22,33,44 at full rate -> col0 pushes 0x11 then 0x22, col1 pushes 0x33 then 0x44; each exactly one cycle after its handshake; no overlap.
- LOAD_ACT 02,02,05,06,07,08 -> init_act_valid twice with 0x0605 then 0x0807. in_valid gapped randomly -> same data, same pulse count.
- LOAD_ACT count 0x11 -> err=1, resp ERR_RESP, next byte decoded as an opcode. Count 0 -> no strobe.
- WEIGHTS_READY with mlp_state=7 for 5 cycles then 1 -> weights_ready high for exactly 6 cycles, then 0. With mlp_state stuck at 7 -> drop at cycle 1023, ERR_RESP.
- WAIT_DONE, layer_complete rises after 40 cycles, resp_ready low for 3 cycles -> resp_valid=1, data 0xA5 held stable, one transfer, then IDLE.
- Reset asserted mid-LOAD_W after byte 2 -> outputs 0 immediately. Afterwards opcode 0x03 -> start_mlp pulse, no stray pushes.
